// File: rtl/calc_result_serializer.sv
// calc_result_serializer
// Captures the operands and the four results of the 6-bit calculator in one
// cycle, then emits them one at a time as tagged OUT_W-bit words over a
// valid/ready handshake (tag 0 add, 1 sub, 2 mul, 3 div).
//
// Optional feature macro: CALC_SER_DIV0_CHECK_EN
//   defined   -> a captured divisor of zero turns the div word into all-ones
//                with o_err set
//   undefined -> the div word is the zero-extended quotient, o_err is tied 0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for i_start; outputs quiet
// ST_SEND   | presenting word idx_q, advancing on every valid && ready edge
// ST_DONE   | one-cycle o_done pulse after the last word was accepted
//
// Output words are registered and only change on a capture or a transfer
// edge, so they stay stable under backpressure and no combinational path
// exists from i_ready to any output.

module calc_result_serializer #(
    parameter int WIDTH = 6,
    parameter int OUT_W = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_data1,
    input  logic [WIDTH-1:0]   i_data2,
    input  logic [WIDTH:0]     i_add,
    input  logic [WIDTH:0]     i_sub,
    input  logic [2*WIDTH-1:0] i_mul,
    input  logic [WIDTH-1:0]   i_div,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [1:0]         o_tag,
    output logic [OUT_W-1:0]   o_result,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         idx_q;

    // holding registers; add goes straight into the output word at capture
    logic [WIDTH:0]     sub_q;
    logic [2*WIDTH-1:0] mul_q;
    logic [WIDTH-1:0]   div_q;

    logic [1:0]         tag_q;
    logic [OUT_W-1:0]   result_q;

    logic               capture;
    logic               transfer;
    logic               last_xfer;
    logic [OUT_W-1:0]   next_result;
    logic               next_err;
    logic [OUT_W-1:0]   add_norm;

`ifdef CALC_SER_DIV0_CHECK_EN
    logic               div0_q;
    logic               err_q;
    // operand 1 is only forwarded to the calculator; nothing here consumes it
    logic               unused_inputs;
    assign unused_inputs = ^i_data1;
`else
    // without the divide-by-zero check neither operand is needed here
    logic               unused_inputs;
    assign unused_inputs = ^{i_data1, i_data2};
`endif

    assign capture   = (state_q == ST_IDLE) && i_start;
    assign transfer  = (state_q == ST_SEND) && i_ready;
    assign last_xfer = transfer && (idx_q == 2'd3);
    assign add_norm  = {{(OUT_W-WIDTH-1){1'b0}}, i_add};

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start)   state_d = ST_SEND;
            ST_SEND: if (last_xfer) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // status outputs decoded from the registered state only
    always_comb begin
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_SEND: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // word that follows the one currently presented; after tag 3 the output
    // returns to the quiet all-zero word
    always_comb begin
        next_result = '0;
        next_err    = 1'b0;
        case (idx_q)
            2'd0: next_result = {{(OUT_W-WIDTH-1){sub_q[WIDTH]}}, sub_q};
            2'd1: next_result = mul_q;
            2'd2: begin
`ifdef CALC_SER_DIV0_CHECK_EN
                if (div0_q) begin
                    next_result = {OUT_W{1'b1}};
                    next_err    = 1'b1;
                end else begin
                    next_result = {{(OUT_W-WIDTH){1'b0}}, div_q};
                end
`else
                next_result = {{(OUT_W-WIDTH){1'b0}}, div_q};
`endif
            end
            default: ;
        endcase
    end

    // capture of calculator results and word sequencing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q    <= 2'd0;
            sub_q    <= '0;
            mul_q    <= '0;
            div_q    <= '0;
            tag_q    <= 2'd0;
            result_q <= '0;
        end else if (capture) begin
            idx_q    <= 2'd0;
            sub_q    <= i_sub;
            mul_q    <= i_mul;
            div_q    <= i_div;
            tag_q    <= 2'd0;
            result_q <= add_norm;
        end else if (transfer) begin
            idx_q    <= idx_q + 2'd1;
            tag_q    <= idx_q + 2'd1;
            result_q <= next_result;
        end
    end

`ifdef CALC_SER_DIV0_CHECK_EN
    // divisor-zero flag is taken at capture so later operand changes are moot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div0_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (capture) begin
            div0_q <= (i_data2 == '0);
            err_q  <= 1'b0;
        end else if (transfer) begin
            err_q  <= next_err;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_tag    = tag_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_calc_result_serializer.sv
// Directed bench for calc_result_serializer: table of operand pairs with
// hand-computed words, plus sequences for backpressure, ignored starts and
// asynchronous reset mid-sequence.

module tb_calc_result_serializer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  data1, data2;
    logic [6:0]  add_v, sub_v;
    logic [11:0] mul_v;
    logic [5:0]  div_v;
    logic        ready;
    logic        valid;
    logic [1:0]  tag;
    logic [11:0] result;
    logic        err;
    logic        busy;
    logic        done;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    calc_result_serializer #(.WIDTH(6), .OUT_W(12)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_data1  (data1),
        .i_data2  (data2),
        .i_add    (add_v),
        .i_sub    (sub_v),
        .i_mul    (mul_v),
        .i_div    (div_v),
        .i_ready  (ready),
        .o_valid  (valid),
        .o_tag    (tag),
        .o_result (result),
        .o_err    (err),
        .o_busy   (busy),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       d1;
        logic [5:0]       d2;
        logic [3:0][11:0] w;
        logic             err3;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // upstream calculator; the divider returns all-ones for a zero divisor
    task automatic drive_ops(input logic [5:0] a, input logic [5:0] b);
        data1 = a;
        data2 = b;
        add_v = {1'b0, a} + {1'b0, b};
        sub_v = {1'b0, a} - {1'b0, b};
        mul_v = {6'd0, a} * {6'd0, b};
        div_v = (b == 6'd0) ? 6'h3F : a / b;
    endtask

    task automatic chk_word(input string name, input logic [1:0] t, input logic [11:0] w, input logic e);
        chk({name, " valid"}, {31'd0, valid}, 32'd1);
        chk({name, " busy"},  {31'd0, busy},  32'd1);
        chk({name, " tag"},   {30'd0, tag},   {30'd0, t});
        chk({name, " result"}, {20'd0, result}, {20'd0, w});
        chk({name, " err"},   {31'd0, err},   {31'd0, e});
    endtask

    task automatic chk_quiet(input string name, input logic exp_done);
        chk({name, " valid"}, {31'd0, valid}, 32'd0);
        chk({name, " busy"},  {31'd0, busy},  32'd0);
        chk({name, " done"},  {31'd0, done},  {31'd0, exp_done});
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string nm;
        nm = $sformatf("vec%0d", n);
        drive_ops(v.d1, v.d2);
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        drive_ops(~v.d1, v.d1 ^ 6'h15);
        for (int k = 0; k < 4; k++) begin
            chk_word($sformatf("%s w%0d", nm, k), 2'(k), v.w[k], (k == 3) ? v.err3 : 1'b0);
            step();
        end
        chk_quiet({nm, " done cycle"}, 1'b1);
        step();
        chk_quiet({nm, " after done"}, 1'b0);
    endtask

    initial begin
        int t0;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        drive_ops(6'd0, 6'd0);

        vecs[0] = '{d1: 6'd20, d2: 6'd5,  w: {12'h004, 12'h064, 12'h00F, 12'h019}, err3: 1'b0};
        vecs[1] = '{d1: 6'd5,  d2: 6'd20, w: {12'h000, 12'h064, 12'hFF1, 12'h019}, err3: 1'b0};
        vecs[2] = '{d1: 6'd63, d2: 6'd63, w: {12'h001, 12'hF81, 12'h000, 12'h07E}, err3: 1'b0};
`ifdef CALC_SER_DIV0_CHECK_EN
        vecs[3] = '{d1: 6'd9,  d2: 6'd0,  w: {12'hFFF, 12'h000, 12'h009, 12'h009}, err3: 1'b1};
`else
        vecs[3] = '{d1: 6'd9,  d2: 6'd0,  w: {12'h03F, 12'h000, 12'h009, 12'h009}, err3: 1'b0};
`endif

        // reset state
        step();
        step();
        chk_quiet("reset", 1'b0);
        chk("reset tag",    {30'd0, tag},    32'd0);
        chk("reset result", {20'd0, result}, 32'd0);
        chk("reset err",    {31'd0, err},    32'd0);
        rst = 1'b0;
        step();
        chk_quiet("idle", 1'b0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // backpressure: ready low for 3 cycles while tag 1 is presented
        drive_ops(6'd20, 6'd5);
        start = 1'b1;
        ready = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
        chk_word("bp w0", 2'd0, 12'h019, 1'b0);
        step();
        ready = 1'b0;
        drive_ops(6'd1, 6'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word($sformatf("bp hold%0d", i), 2'd1, 12'h00F, 1'b0);
            drive_ops(6'(i + 7), 6'(i + 33));
        end
        ready = 1'b1;
        step();
        chk_word("bp w2", 2'd2, 12'h064, 1'b0);
        step();
        chk_word("bp w3", 2'd3, 12'h004, 1'b0);
        step();
        chk_quiet("bp done", 1'b1);
        chk("bp done latency", cyc - t0, 32'd7);
        step();

        // start ignored during SEND and during the done cycle
        drive_ops(6'd20, 6'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        drive_ops(6'd1, 6'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_word("ign w2", 2'd2, 12'h064, 1'b0);
        step();
        chk_word("ign w3", 2'd3, 12'h004, 1'b0);
        drive_ops(6'd63, 6'd63);
        step();
        chk_quiet("ign done", 1'b1);
        start = 1'b1;
        step();
        chk_quiet("ign start in done", 1'b0);
        step();
        start = 1'b0;
        chk_word("restart w0", 2'd0, 12'h07E, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_quiet("restart done", 1'b1);
        step();

        // asynchronous reset while tag 2 is pending
        drive_ops(6'd20, 6'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b1;
        step();
        step();
        chk_word("rst pre", 2'd2, 12'h064, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("rst async", 1'b0);
        chk("rst async tag",    {30'd0, tag},    32'd0);
        chk("rst async result", {20'd0, result}, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet($sformatf("rst no done%0d", i), 1'b0);
        end
        run_vec(vecs[2], 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_result_serializer.md
# calc_result_serializer

Sequential stage directly downstream of the combinational 6-bit calculator. On a start request it captures the operands and the four calculator results (add, sub, mul, div) in a single cycle. It then emits them one at a time as tagged, 12-bit-normalised words over a valid/ready handshake. This decouples the calculator from a slower consumer such as a display driver or UART packer.

## Interface
Parameters:
- `WIDTH`, 6, operand width; fixes result widths: add/sub WIDTH+1, mul 2·WIDTH, div WIDTH
- `OUT_W`, 12, output word width; must equal 2·WIDTH

Ports:
- `i_clk`  in  1  single clock; all state changes on its rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_start`  in  1  capture request; sampled only while idle
- `i_data1`  in  WIDTH  operand 1, the same value driven into the calculator
- `i_data2`  in  WIDTH  operand 2, used for divide-by-zero detection
- `i_add`  in  WIDTH+1  calculator sum, unsigned
- `i_sub`  in  WIDTH+1  calculator difference; bit WIDTH is the sign (two's complement)
- `i_mul`  in  2·WIDTH  calculator product, unsigned
- `i_div`  in  WIDTH  calculator quotient, unsigned
- `i_ready`  in  1  consumer accepts the current word
- `o_valid`  out  1  current word valid
- `o_tag`  out  2  word identity: 0 add, 1 sub, 2 mul, 3 div
- `o_result`  out  OUT_W  normalised result word
- `o_err`  out  1  error flag qualifying the current word
- `o_busy`  out  1  capture taken, sequence not finished
- `o_done`  out  1  one-cycle pulse after the last word is accepted

## Operation
- FSM states:
  - IDLE: outputs quiet; `i_start`=1 captures all inputs into holding registers, sets index 0, goes to SEND.
  - SEND: `o_valid`=1. A transfer occurs on any edge with `o_valid`&&`i_ready`. Index increments on each transfer; the transfer at index 3 moves the FSM to DONE.
  - DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Normalisation of captured values to OUT_W:
  - add, mul, div: zero-extended.
  - sub: sign-extended from bit WIDTH, so 5−20 gives 0xFF1.
- The calculator inputs are never re-sampled after capture. Upstream may change operands freely while `o_busy`=1.
- `i_start` is ignored in SEND and DONE. No queuing: a start pulse during a busy sequence is lost.
- `o_err`=0 on tags 0–2 in all builds.
- `o_tag`, `o_result`, `o_err` change only on a transfer edge. They are held stable while `o_valid`=1 and `i_ready`=0.
- Reset values: `o_valid`=0, `o_tag`=0, `o_result`=0, `o_err`=0, `o_busy`=0, `o_done`=0, FSM=IDLE, index=0, holding registers=0.
- Reset mid-sequence clears everything asynchronously. Words not yet transferred are discarded and no `o_done` is produced.

## Timing
- `i_start` sampled at edge N: `o_busy`=1 and `o_valid`=1 with tag 0 from N+1.
- With `i_ready` held high, tags 0..3 transfer at edges N+1..N+4. `o_done`=1 in cycle N+5, and `o_busy` and `o_valid` are 0 from N+5.
- `o_busy` is high from N+1 until the last transfer edge. It is low during the `o_done` cycle. A new `i_start` is accepted from the edge ending the `o_done` cycle onward.
- Backpressure adds exactly one cycle per cycle of `i_ready`=0. There is no other latency and no combinational path from `i_ready` to any output.

## Configuration
- Macro `CALC_SER_DIV0_CHECK_EN`, defined:
  - If captured `i_data2`==0, the tag-3 word is `o_result`=0xFFF with `o_err`=1, regardless of `i_div`.
  - Otherwise `o_err`=0.
- Undefined:
  - The tag-3 word is zero-extended captured `i_div`, and `o_err` is constant 0.
  - No comparator on `i_data2` is synthesised.

## Test plan
- data1=20, data2=5 (add 25, sub 0x0F, mul 100, div 4), `i_ready`=1, start at N -> words (0,0x019),(1,0x00F),(2,0x064),(3,0x004) at N+1..N+4; `o_done` at N+5.
- data1=5, data2=20 (sub 7'h71) -> tag-1 word 0xFF1; data1=63, data2=63 -> add 0x07E, sub 0x000, mul 0xF81, div 0x001.
- Divide by zero, data1=9, data2=0:
  - With `CALC_SER_DIV0_CHECK_EN`: tag-3 word 0xFFF, `o_err`=1.
  - Without: tag-3 word = zero-extended `i_div`, `o_err`=0.
- `i_ready`=0 for 3 cycles while tag 1 is presented, upstream operands changed mid-sequence -> tag/result/err stable; `o_done` delayed by exactly 3 cycles; captured values unchanged.
- `i_start` pulsed during SEND and during the `o_done` cycle -> both ignored; a start one cycle after `o_done` -> new sequence begins on the next cycle.
- `i_rst` asserted between edges while tag 2 is pending -> all outputs 0 immediately (async); no `o_done`; the next start begins a fresh sequence at tag 0.
